msdap_ctrl_fsm: RTL and testbench

- Top-level sequencing controller for the stereo audio filter datapath. Runs in the SCLK domain.
- Consumes the one-cycle frame pulse from the DCLK-to-SCLK frame synchroniser and the all-zeros detector output.
- Steps the chip through memory clear, Rj load, coefficient load, working and sleep.
- Generates every memory write strobe, address, detector control and filter-engine start.

---
 rtl/msdap_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_msdap_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msdap_ctrl_fsm.sv
// Top-level sequencing controller for the stereo filter datapath (SCLK domain).
// Drives memory clear, Rj/coefficient load, working/sleep and all memory strobes.
module msdap_ctrl_fsm #(
    parameter int RJ_COUNT    = 16,
    parameter int COEFF_COUNT = 512,
    parameter int DATA_DEPTH  = 256
) (
    input  logic                           SCLK,
    input  logic                           Reset_n,
    input  logic                           Start,
    input  logic                           FramePulse,
    input  logic [15:0]                    dataL,
    input  logic [15:0]                    dataR,
    input  logic                           all_zeros,
    input  logic                           compute_busy,
    output logic                           InReady,
    output logic [2:0]                     state,
    output logic                           rj_we,
    output logic [$clog2(RJ_COUNT)-1:0]    rj_addr,
    output logic                           coeff_we,
    output logic [$clog2(COEFF_COUNT)-1:0] coeff_addr,
    output logic                           data_we,
    output logic                           data_clr,
    output logic [$clog2(DATA_DEPTH)-1:0]  data_addr,
    output logic                           zd_enable,
    output logic                           zd_clear,
    output logic                           compute_start,
    output logic                           sleep,
    output logic                           overrun
);
    localparam int RW = $clog2(RJ_COUNT);
    localparam int CW = $clog2(COEFF_COUNT);
    localparam int DW = $clog2(DATA_DEPTH);
    localparam logic [RW-1:0] RJ_LAST    = RW'(RJ_COUNT - 1);
    localparam logic [CW-1:0] COEFF_LAST = CW'(COEFF_COUNT - 1);
    localparam logic [DW-1:0] DATA_LAST  = DW'(DATA_DEPTH - 1);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_READ_RJ    = 3'd1,
        S_READ_COEFF = 3'd2,
        S_WORKING    = 3'd3,
        S_SLEEP      = 3'd4
    } state_t;

    state_t st, st_nxt;

    logic          frm_wr, frm_wr_d;
    logic          rj_we_d, coeff_we_d, data_we_d, data_clr_d;
    logic          zd_enable_d, zd_clear_d, compute_start_d, overrun_d;
    logic          in_ready_d, sleep_d;
    logic [RW-1:0] rj_inc, rj_tgt, rj_addr_d;
    logic [CW-1:0] coeff_inc, coeff_tgt, coeff_addr_d;
    logic [DW-1:0] data_inc, data_addr_d;
    logic          nonzero;

    assign rj_inc    = (rj_addr == RJ_LAST) ? '0 : rj_addr + 1'b1;
    assign coeff_inc = (coeff_addr == COEFF_LAST) ? '0 : coeff_addr + 1'b1;
    assign data_inc  = (data_addr == DATA_LAST) ? '0 : data_addr + 1'b1;
    // Address the next frame lands on: a write still in flight has already claimed rj_addr
    assign rj_tgt    = rj_we ? rj_inc : rj_addr;
    assign coeff_tgt = coeff_we ? coeff_inc : coeff_addr;
    assign nonzero   = (dataL != 16'h0) || (dataR != 16'h0);

    assign state = st;

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) st <= S_INIT;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (Start) begin
            st_nxt = S_INIT;
        end else begin
            case (st)
                S_INIT:       if (data_we && data_addr == DATA_LAST) st_nxt = S_READ_RJ;
                S_READ_RJ:    if (FramePulse && rj_tgt == RJ_LAST) st_nxt = S_READ_COEFF;
                S_READ_COEFF: if (FramePulse && coeff_tgt == COEFF_LAST) st_nxt = S_WORKING;
                S_WORKING:    if (!FramePulse && all_zeros && !compute_busy && !data_we && !compute_start)
                                  st_nxt = S_SLEEP;
                S_SLEEP:      if (FramePulse && nonzero) st_nxt = S_WORKING;
                default:      st_nxt = S_INIT;
            endcase
        end
    end

    always_comb begin
        rj_we_d         = 1'b0;
        coeff_we_d      = 1'b0;
        data_we_d       = 1'b0;
        data_clr_d      = 1'b0;
        zd_enable_d     = 1'b0;
        zd_clear_d      = 1'b0;
        compute_start_d = 1'b0;
        frm_wr_d        = 1'b0;
        overrun_d       = overrun;
        rj_addr_d       = rj_tgt;
        coeff_addr_d    = coeff_tgt;
        data_addr_d     = data_we ? data_inc : data_addr;
        if (Start) begin
            rj_addr_d    = '0;
            coeff_addr_d = '0;
            data_addr_d  = '0;
            overrun_d    = 1'b0;
            zd_clear_d   = 1'b1;
        end else begin
            // A frame written last cycle starts the engine only if it is idle right now
            compute_start_d = frm_wr && !compute_busy;
            if (frm_wr && compute_busy) overrun_d = 1'b1;
            case (st)
                S_INIT: begin
                    if (st_nxt == S_INIT) begin
                        data_we_d  = 1'b1;
                        data_clr_d = 1'b1;
                    end
                end
                S_READ_RJ: rj_we_d = FramePulse;
                S_READ_COEFF: begin
                    coeff_we_d = FramePulse;
                    zd_clear_d = (st_nxt == S_WORKING);
                end
                S_WORKING: begin
                    data_we_d   = FramePulse;
                    frm_wr_d    = FramePulse;
                    zd_enable_d = FramePulse;
                end
                S_SLEEP: begin
                    zd_enable_d = FramePulse;
                    if (st_nxt == S_WORKING) begin
                        data_we_d  = 1'b1;
                        frm_wr_d   = 1'b1;
                        zd_clear_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        in_ready_d = (st_nxt != S_INIT);
        sleep_d    = (st_nxt == S_SLEEP);
    end

    // zd_clear comes out of reset high so the detector starts from a clean count
    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            InReady       <= 1'b0;
            rj_we         <= 1'b0;
            rj_addr       <= '0;
            coeff_we      <= 1'b0;
            coeff_addr    <= '0;
            data_we       <= 1'b0;
            data_clr      <= 1'b0;
            data_addr     <= '0;
            zd_enable     <= 1'b0;
            zd_clear      <= 1'b1;
            compute_start <= 1'b0;
            sleep         <= 1'b0;
            overrun       <= 1'b0;
            frm_wr        <= 1'b0;
        end else begin
            InReady       <= in_ready_d;
            rj_we         <= rj_we_d;
            rj_addr       <= rj_addr_d;
            coeff_we      <= coeff_we_d;
            coeff_addr    <= coeff_addr_d;
            data_we       <= data_we_d;
            data_clr      <= data_clr_d;
            data_addr     <= data_addr_d;
            zd_enable     <= zd_enable_d;
            zd_clear      <= zd_clear_d;
            compute_start <= compute_start_d;
            sleep         <= sleep_d;
            overrun       <= overrun_d;
            frm_wr        <= frm_wr_d;
        end
    end
endmodule

// File: tb/tb_msdap_ctrl_fsm.sv
// Bench for msdap_ctrl_fsm: directed vectors plus randomized frames against a
// count-based behavioural model of the load/work/sleep sequence.
`timescale 1ns/1ps
module tb_msdap_ctrl_fsm;
    localparam int RJ = 16;
    localparam int CO = 512;
    localparam int DD = 256;

    logic        SCLK = 1'b0, Reset_n = 1'b1, Start = 1'b0, FramePulse = 1'b0;
    logic        all_zeros = 1'b0, compute_busy = 1'b0;
    logic [15:0] dataL = 16'h0, dataR = 16'h0;
    logic        InReady, rj_we, coeff_we, data_we, data_clr;
    logic        zd_enable, zd_clear, compute_start, sleep, overrun;
    logic [2:0]  state;
    logic [3:0]  rj_addr;
    logic [8:0]  coeff_addr;
    logic [7:0]  data_addr;

    msdap_ctrl_fsm #(.RJ_COUNT(RJ), .COEFF_COUNT(CO), .DATA_DEPTH(DD)) dut (
        .SCLK(SCLK), .Reset_n(Reset_n), .Start(Start), .FramePulse(FramePulse),
        .dataL(dataL), .dataR(dataR), .all_zeros(all_zeros), .compute_busy(compute_busy),
        .InReady(InReady), .state(state), .rj_we(rj_we), .rj_addr(rj_addr),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .data_we(data_we), .data_clr(data_clr),
        .data_addr(data_addr), .zd_enable(zd_enable), .zd_clear(zd_clear),
        .compute_start(compute_start), .sleep(sleep), .overrun(overrun)
    );

    always #5 SCLK = ~SCLK;

    typedef struct packed {
        logic       InReady;
        logic [2:0] state;
        logic       rj_we;
        logic [3:0] rj_addr;
        logic       coeff_we;
        logic [8:0] coeff_addr;
        logic       data_we;
        logic       data_clr;
        logic [7:0] data_addr;
        logic       zd_enable;
        logic       zd_clear;
        logic       compute_start;
        logic       sleep;
        logic       overrun;
    } outs_t;

    outs_t act, exp;
    assign act = {InReady, state, rj_we, rj_addr, coeff_we, coeff_addr, data_we, data_clr,
                  data_addr, zd_enable, zd_clear, compute_start, sleep, overrun};

    int checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Model: mode in spec encoding, frames counted as integers; an address is the
    // number of writes already completed modulo the memory size.
    int m_mode, m_k, n_rj_acc, n_co_acc, n_rj_done, n_co_done, n_d_done;
    bit m_ovr, cs_cand;

    task automatic model_reset();
        m_mode = 0; m_k = 0; n_rj_acc = 0; n_co_acc = 0;
        n_rj_done = 0; n_co_done = 0; n_d_done = 0; m_ovr = 0; cs_cand = 0;
        exp = '0;
        exp.zd_clear = 1'b1;
    endtask

    task automatic model_edge();
        outs_t n;
        n = '0;
        if (exp.rj_we)    n_rj_done++;
        if (exp.coeff_we) n_co_done++;
        if (exp.data_we)  n_d_done++;
        if (Start) begin
            m_mode = 0; m_k = 0; n_rj_acc = 0; n_co_acc = 0;
            n_rj_done = 0; n_co_done = 0; n_d_done = 0; m_ovr = 0; cs_cand = 0;
            n.zd_clear = 1'b1;
        end else begin
            if (cs_cand) begin
                if (!compute_busy) n.compute_start = 1'b1;
                else               m_ovr = 1'b1;
            end
            cs_cand = 0;
            case (m_mode)
                0: begin
                    m_k++;
                    if (m_k <= DD) begin n.data_we = 1'b1; n.data_clr = 1'b1; end
                    else m_mode = 1;
                end
                1: if (FramePulse) begin
                    n.rj_we = 1'b1; n_rj_acc++;
                    if (n_rj_acc == RJ) m_mode = 2;
                end
                2: if (FramePulse) begin
                    n.coeff_we = 1'b1; n_co_acc++;
                    if (n_co_acc == CO) begin m_mode = 3; n.zd_clear = 1'b1; end
                end
                3: if (FramePulse) begin
                    n.data_we = 1'b1; n.zd_enable = 1'b1; cs_cand = 1;
                end else if (all_zeros && !compute_busy && !exp.data_we && !exp.compute_start) begin
                    m_mode = 4;
                end
                default: if (FramePulse) begin
                    n.zd_enable = 1'b1;
                    if (dataL != 0 || dataR != 0) begin
                        m_mode = 3; n.data_we = 1'b1; n.zd_clear = 1'b1; cs_cand = 1;
                    end
                end
            endcase
        end
        n.state      = 3'(m_mode);
        n.InReady    = (m_mode != 0);
        n.sleep      = (m_mode == 4);
        n.overrun    = m_ovr;
        n.rj_addr    = 4'(n_rj_done % RJ);
        n.coeff_addr = 9'(n_co_done % CO);
        n.data_addr  = 8'(n_d_done % DD);
        exp = n;
    endtask

    always @(posedge SCLK) if (Reset_n) model_edge();

    task automatic tick();
        @(posedge SCLK);
        @(negedge SCLK);
        cyc++;
        chk($sformatf("cycle%0d", cyc), 64'(act), 64'(exp));
    endtask

    task automatic idle(input int n);
        FramePulse = 1'b0; Start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        FramePulse = 1'b1; dataL = l; dataR = r;
        tick();
        FramePulse = 1'b0;
    endtask

    task automatic load_rj();
        for (int i = 0; i < RJ; i++) begin
            frame(16'(i), 16'(i + 7));
            chk($sformatf("rj_wr%0d", i), 64'({rj_we, rj_addr}), 64'({1'b1, 4'(i)}));
            if (i % 4 == 1) idle(1);
        end
        chk("rj_done_state", 64'(state), 64'd2);
    endtask

    task automatic load_coeff(input int n);
        for (int i = 0; i < n; i++) frame(16'(i * 3 + 1), 16'(i));
        if (n == CO) begin
            chk("coeff_done_state", 64'(state), 64'd3);
            chk("coeff_done_zdclr", 64'({coeff_we, coeff_addr, zd_clear}), 64'({1'b1, 9'd511, 1'b1}));
        end
    endtask

    typedef struct {
        logic        fp;
        logic [15:0] dl, dr;
        logic [2:0]  ctl;   // {compute_busy, all_zeros, Start}
        logic [2:0]  st;
        logic        dwe;
        logic [7:0]  da;
        logic [4:0]  fl;    // {compute_start, overrun, sleep, zd_enable, zd_clear}
    } vec_t;
    vec_t tbl[14];

    initial begin
        int clr_cnt, fp_pct;
        tbl[0]  = '{1'b1, 16'h5, 16'h0, 3'b000, 3'd3, 1'b1, 8'd0, 5'b00010};
        tbl[1]  = '{1'b1, 16'h6, 16'h0, 3'b000, 3'd3, 1'b1, 8'd1, 5'b10010};
        tbl[2]  = '{1'b1, 16'h7, 16'h0, 3'b000, 3'd3, 1'b1, 8'd2, 5'b10010};
        tbl[3]  = '{1'b0, 16'h0, 16'h0, 3'b000, 3'd3, 1'b0, 8'd3, 5'b10000};
        tbl[4]  = '{1'b0, 16'h0, 16'h0, 3'b000, 3'd3, 1'b0, 8'd3, 5'b00000};
        tbl[5]  = '{1'b1, 16'h8, 16'h0, 3'b100, 3'd3, 1'b1, 8'd3, 5'b00010};
        tbl[6]  = '{1'b0, 16'h0, 16'h0, 3'b100, 3'd3, 1'b0, 8'd4, 5'b01000};
        tbl[7]  = '{1'b0, 16'h0, 16'h0, 3'b000, 3'd3, 1'b0, 8'd4, 5'b01000};
        tbl[8]  = '{1'b0, 16'h0, 16'h0, 3'b010, 3'd4, 1'b0, 8'd4, 5'b01100};
        tbl[9]  = '{1'b1, 16'h0, 16'h0, 3'b010, 3'd4, 1'b0, 8'd4, 5'b01110};
        tbl[10] = '{1'b0, 16'h0, 16'h0, 3'b010, 3'd4, 1'b0, 8'd4, 5'b01100};
        tbl[11] = '{1'b1, 16'h1, 16'h0, 3'b010, 3'd3, 1'b1, 8'd4, 5'b01011};
        tbl[12] = '{1'b0, 16'h0, 16'h0, 3'b000, 3'd3, 1'b0, 8'd5, 5'b11000};
        tbl[13] = '{1'b0, 16'h0, 16'h0, 3'b001, 3'd0, 1'b0, 8'd0, 5'b00001};

        model_reset();
        #1 Reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_state", 64'({state, InReady, sleep, overrun}), 64'({3'd0, 1'b0, 1'b0, 1'b0}));
        chk("rst_zdclr", 64'(zd_clear), 64'd1);
        Reset_n = 1'b1;

        clr_cnt = 0;
        for (int i = 0; i < 258; i++) begin
            tick();
            if (data_we && data_clr) clr_cnt++;
        end
        chk("init_clr_cycles", 64'(clr_cnt), 64'd256);
        chk("init_done", 64'({state, InReady}), 64'({3'd1, 1'b1}));

        load_rj();
        load_coeff(CO);
        idle(2);

        for (int i = 0; i < 14; i++) begin
            FramePulse = tbl[i].fp; dataL = tbl[i].dl; dataR = tbl[i].dr;
            {compute_busy, all_zeros, Start} = tbl[i].ctl;
            tick();
            chk($sformatf("vec%0d", i),
                64'({state, data_we, data_addr, compute_start, overrun, sleep, zd_enable, zd_clear}),
                64'({tbl[i].st, tbl[i].dwe, tbl[i].da, tbl[i].fl}));
        end
        FramePulse = 1'b0; Start = 1'b0; compute_busy = 1'b0; all_zeros = 1'b0;

        // Frames during the clear must be ignored
        for (int i = 0; i < 257; i++) begin
            FramePulse = 1'($urandom_range(0, 1)); dataL = 16'($urandom);
            tick();
        end
        FramePulse = 1'b0;
        chk("reinit_done", 64'({state, rj_addr, data_addr}), 64'({3'd1, 4'd0, 8'd0}));

        load_rj();
        load_coeff(CO);
        for (int i = 0; i < 258; i++) begin
            frame(16'($urandom_range(1, 65535)), 16'($urandom));
            if (i == 255) chk("wrap_last", 64'({data_we, data_addr}), 64'({1'b1, 8'd255}));
            if (i == 256) chk("wrap_first", 64'({data_we, data_addr}), 64'({1'b1, 8'd0}));
        end
        idle(3);

        Start = 1'b1; tick(); Start = 1'b0;
        idle(257);
        chk("restart_state", 64'(state), 64'd1);
        load_rj();
        load_coeff(100);
        idle(2);
        chk("mid_coeff_addr", 64'(coeff_addr), 64'd100);
        Reset_n = 1'b0;
        #1;
        chk("async_rst", 64'({state, rj_addr, coeff_addr, data_addr, coeff_we, InReady}), 64'(0));
        model_reset();
        repeat (2) tick();
        Reset_n = 1'b1;
        idle(258);
        chk("post_rst_init", 64'({state, InReady}), 64'({3'd1, 1'b1}));

        for (int seg = 0; seg < 3; seg++) begin
            fp_pct = (seg == 0) ? 70 : (seg == 1) ? 95 : 40;
            for (int i = 0; i < 4000; i++) begin
                FramePulse   = ($urandom_range(0, 99) < fp_pct);
                dataL        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
                dataR        = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
                compute_busy = ($urandom_range(0, 3) == 0);
                if (i % 150 == 0) all_zeros = 1'($urandom_range(0, 1));
                Start        = ($urandom_range(0, 2999) == 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
